// File: rtl/pila_param_if.sv
// Bus bundle for the pila_param return-address stack: call/return strobes,
// push data, popped data and status.
interface pila_param_if #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             push;
   logic             pop;
   logic             clr_err;
   logic [WIDTH-1:0] inpush;
   logic [WIDTH-1:0] outpop;
   logic [WIDTH-1:0] top;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             ovf;
   logic             udf;

   modport master (
      output push, pop, clr_err, inpush,
      input  outpop, top, count, full, empty, ovf, udf
   );

   modport slave (
      input  push, pop, clr_err, inpush,
      output outpop, top, count, full, empty, ovf, udf
   );
endinterface

// File: rtl/pila_param.sv
// Parametrised LIFO for the call/return path: push, pop, replace-top and
// empty-stack bypass, with sticky overflow/underflow flags and a wrap option.
module pila_param #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   parameter int WRAP  = 0
) (
   input  logic         clk,
   input  logic         reset,
   pila_param_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    sp_q, sp_d;
   logic [AW-1:0]    sp_m1;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] outpop_q, outpop_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             full, empty;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] top;

   assign sp_m1 = sp_q - 1'b1;
   assign top   = mem_q[sp_m1];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   always_comb begin
      sp_d      = sp_q;
      count_d   = count_q;
      outpop_d  = outpop_q;
      ovf_d     = ovf_q & ~bus.clr_err;
      udf_d     = udf_q & ~bus.clr_err;
      mem_we    = 1'b0;
      mem_waddr = sp_q;
      mem_wdata = bus.inpush;
      case ({bus.push, bus.pop})
         2'b10: begin
            if (!full) begin
               mem_we  = 1'b1;
               sp_d    = sp_q + 1'b1;
               count_d = count_q + 1'b1;
            end else begin
               ovf_d = 1'b1;
               // Wrap mode overwrites the oldest slot, which is exactly sp when full.
               if (WRAP != 0) begin
                  mem_we = 1'b1;
                  sp_d   = sp_q + 1'b1;
               end
            end
         end
         2'b01: begin
            if (!empty) begin
               outpop_d = top;
               sp_d     = sp_m1;
               count_d  = count_q - 1'b1;
            end else begin
               udf_d = 1'b1;
            end
         end
         2'b11: begin
            if (!empty) begin
               outpop_d  = top;
               mem_we    = 1'b1;
               mem_waddr = sp_m1;
            end else begin
               outpop_d = bus.inpush;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp_q     <= '0;
         count_q  <= '0;
         outpop_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         sp_q     <= sp_d;
         count_q  <= count_d;
         outpop_q <= outpop_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is deliberately not reset; only the pointer/count define validity.
   always_ff @(posedge clk) begin
      if (mem_we && reset)
         mem_q[mem_waddr] <= mem_wdata;
   end

   assign bus.outpop = outpop_q;
   assign bus.top    = top;
   assign bus.count  = count_q;
   assign bus.full   = full;
   assign bus.empty  = empty;
   assign bus.ovf    = ovf_q;
   assign bus.udf    = udf_q;
endmodule

// File: tb/tb_pila_param.sv
// Bench for pila_param: a WRAP=0 and a WRAP=1 instance share one stimulus and
// are each checked every cycle against an ordered-list model of the stack.
module tb_pila_param;
   logic       clk;
   logic       reset;
   logic       push_s, pop_s, clr_s;
   logic [9:0] din_s;
   logic       chk_en;
   int         n_checks;
   int         n_fail;

   pila_param_if #(.WIDTH(10), .DEPTH(8)) bus0 ();
   pila_param_if #(.WIDTH(10), .DEPTH(8)) bus1 ();

   assign bus0.push = push_s;  assign bus1.push = push_s;
   assign bus0.pop  = pop_s;   assign bus1.pop  = pop_s;
   assign bus0.clr_err = clr_s; assign bus1.clr_err = clr_s;
   assign bus0.inpush = din_s; assign bus1.inpush = din_s;

   pila_param #(.WIDTH(10), .DEPTH(8), .WRAP(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   pila_param #(.WIDTH(10), .DEPTH(8), .WRAP(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: ent[w][0] is the oldest entry, ent[w][cnt-1] the top.
   logic [9:0] ment [2][8];
   int         mcnt [2];
   logic [9:0] mout [2];
   logic       movf [2];
   logic       mudf [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic mclear();
      for (int w = 0; w < 2; w++) begin
         mcnt[w] = 0; mout[w] = '0; movf[w] = 1'b0; mudf[w] = 1'b0;
      end
   endtask

   task automatic mstep(input int w);
      int n;
      n = mcnt[w];
      if (clr_s) begin movf[w] = 1'b0; mudf[w] = 1'b0; end
      case ({push_s, pop_s})
         2'b10:
            if (n < 8) begin
               ment[w][n] = din_s; mcnt[w] = n + 1;
            end else begin
               movf[w] = 1'b1;
               if (w == 1) begin
                  for (int i = 0; i < 7; i++) ment[w][i] = ment[w][i+1];
                  ment[w][7] = din_s;
               end
            end
         2'b01:
            if (n > 0) begin
               mout[w] = ment[w][n-1]; mcnt[w] = n - 1;
            end else mudf[w] = 1'b1;
         2'b11:
            if (n > 0) begin
               mout[w] = ment[w][n-1]; ment[w][n-1] = din_s;
            end else mout[w] = din_s;
         default: ;
      endcase
   endtask

   task automatic cyc(input logic p, input logic po, input logic c, input logic [9:0] d);
      @(negedge clk);
      push_s = p; pop_s = po; clr_s = c; din_s = d;
      @(posedge clk);
      if (!reset) mclear();
      else begin mstep(0); mstep(1); end
      #1;
   endtask

   task automatic async_rst();
      @(posedge clk);
      #3;
      push_s = 1'b0; pop_s = 1'b0; clr_s = 1'b0;
      reset = 1'b0;
      mclear();
      #1;
      chk("arst_count0", 32'(bus0.count), 32'd0);
      chk("arst_empty0", 32'(bus0.empty), 32'd1);
      chk("arst_outpop0", 32'(bus0.outpop), 32'd0);
      chk("arst_flags0", {30'd0, bus0.ovf, bus0.udf}, 32'd0);
      chk("arst_count1", 32'(bus1.count), 32'd0);
      chk("arst_flags1", {30'd0, bus1.ovf, bus1.udf}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cnt0", 32'(bus0.count), 32'(mcnt[0]));
         chk("full0", 32'(bus0.full), 32'(mcnt[0] == 8));
         chk("empty0", 32'(bus0.empty), 32'(mcnt[0] == 0));
         chk("outpop0", 32'(bus0.outpop), 32'(mout[0]));
         chk("ovf0", 32'(bus0.ovf), 32'(movf[0]));
         chk("udf0", 32'(bus0.udf), 32'(mudf[0]));
         if (mcnt[0] > 0) chk("top0", 32'(bus0.top), 32'(ment[0][mcnt[0]-1]));
         chk("cnt1", 32'(bus1.count), 32'(mcnt[1]));
         chk("full1", 32'(bus1.full), 32'(mcnt[1] == 8));
         chk("empty1", 32'(bus1.empty), 32'(mcnt[1] == 0));
         chk("outpop1", 32'(bus1.outpop), 32'(mout[1]));
         chk("ovf1", 32'(bus1.ovf), 32'(movf[1]));
         chk("udf1", 32'(bus1.udf), 32'(mudf[1]));
         if (mcnt[1] > 0) chk("top1", 32'(bus1.top), 32'(ment[1][mcnt[1]-1]));
      end
   end

   initial begin
      int push_pct;
      n_checks = 0; n_fail = 0; chk_en = 1'b0;
      reset = 1'b0; push_s = 1'b0; pop_s = 1'b0; clr_s = 1'b0; din_s = '0;
      mclear();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      chk_en = 1'b1;
      #1;
      chk("rst_count", 32'(bus0.count), 32'd0);
      chk("rst_empty", 32'(bus0.empty), 32'd1);
      chk("rst_outpop", 32'(bus0.outpop), 32'd0);
      chk("rst_flags", {30'd0, bus0.ovf, bus0.udf}, 32'd0);

      for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 10'(i));
      chk("fill_full", 32'(bus0.full), 32'd1);
      chk("fill_count", 32'(bus0.count), 32'd8);
      chk("fill_top", 32'(bus0.top), 32'h008);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 0, 0);
         chk("pop_seq", 32'(bus0.outpop), 32'(8 - i));
      end
      chk("drain_empty", 32'(bus0.empty), 32'd1);
      chk("drain_flags", {30'd0, bus0.ovf, bus0.udf}, 32'd0);

      for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 10'(i));
      cyc(1, 0, 0, 10'h3FF);
      chk("rej_count", 32'(bus0.count), 32'd8);
      chk("rej_top", 32'(bus0.top), 32'h008);
      chk("rej_ovf", 32'(bus0.ovf), 32'd1);
      chk("wrap_top", 32'(bus1.top), 32'h3FF);
      chk("wrap_ovf", 32'(bus1.ovf), 32'd1);
      cyc(0, 0, 1, 0);
      chk("clr_ovf", 32'(bus0.ovf), 32'd0);

      async_rst();
      for (int i = 1; i <= 10; i++) cyc(1, 0, 0, 10'(i));
      chk("wrap_count", 32'(bus1.count), 32'd8);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 0, 0);
         chk("wrap_pop", 32'(bus1.outpop), 32'(10 - i));
         chk("rej_pop", 32'(bus0.outpop), 32'(8 - i));
      end
      chk("wrap_empty", 32'(bus1.empty), 32'd1);
      chk("wrap_ovf_kept", 32'(bus1.ovf), 32'd1);

      cyc(0, 1, 0, 0);
      chk("udf_set", 32'(bus1.udf), 32'd1);
      chk("udf_outpop", 32'(bus1.outpop), 32'h003);
      cyc(0, 0, 1, 0);
      cyc(1, 1, 0, 10'h155);
      chk("byp_outpop", 32'(bus1.outpop), 32'h155);
      chk("byp_empty", 32'(bus1.empty), 32'd1);
      chk("byp_flags", {30'd0, bus1.ovf, bus1.udf}, 32'd0);

      cyc(1, 0, 0, 10'h011);
      cyc(1, 0, 0, 10'h022);
      cyc(1, 1, 0, 10'h033);
      chk("rep_outpop", 32'(bus0.outpop), 32'h022);
      chk("rep_top", 32'(bus0.top), 32'h033);
      chk("rep_count", 32'(bus0.count), 32'd2);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 10'(10'h040 + i));
      cyc(1, 1, 0, 10'h044);
      chk("repf_count", 32'(bus0.count), 32'd8);
      chk("repf_ovf", 32'(bus0.ovf), 32'd0);
      chk("repf_outpop", 32'(bus0.outpop), 32'h045);
      chk("repf_top", 32'(bus1.top), 32'h044);

      cyc(0, 1, 0, 0);
      async_rst();
      cyc(1, 0, 0, 10'h007);
      chk("post_rst_count", 32'(bus0.count), 32'd1);

      push_pct = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 60 == 0) push_pct = 20 + 20 * int'($urandom_range(0, 3));
         if ($urandom_range(0, 499) == 0) async_rst();
         cyc(logic'($urandom_range(0, 99) < push_pct),
             logic'($urandom_range(0, 99) < (100 - push_pct)),
             logic'($urandom_range(0, 99) < 5),
             10'($urandom));
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pila_param.md
# pila_param

Parametrised hardware stack: the next-generation return-address stack for the CPU's call/return path. It adds configurable data width and depth, full/empty/count status, sticky overflow/underflow error flags, and a same-cycle push+pop (replace-top) operation. It also has a selectable full-stack policy: reject new entries, or wrap and overwrite the oldest entry. It sits beside the PC register; `inpush` takes the return address and `outpop` feeds the PC mux.

## Interface
- `WIDTH`, 10, data width in bits (PC width).
- `DEPTH`, 8, number of entries; power of two, ≥2.
- `WRAP`, 0, full-stack policy: 0 = reject push when full; 1 = circular, overwrite oldest.
- `clk` input 1 — single clock; all state changes on rising edge.
- `reset` input 1 — asynchronous, active-low; clears all control state immediately while low.
- `push` input 1 — push `inpush` this cycle.
- `pop` input 1 — pop top entry this cycle.
- `clr_err` input 1 — synchronous clear of `ovf`/`udf`.
- `inpush` input WIDTH — data to push.
- `outpop` output WIDTH — registered; value removed by the last successful pop.
- `top` output WIDTH — combinational view of the current top entry; undefined when `empty`.
- `count` output $clog2(DEPTH+1) — number of valid entries, 0..DEPTH.
- `full` output 1 — `count == DEPTH`.
- `empty` output 1 — `count == 0`.
- `ovf` output 1 — sticky; set on any push that finds the stack full without a simultaneous pop.
- `udf` output 1 — sticky; set on any pop that finds the stack empty without a simultaneous push.

## Operation
- Storage: `mem[0:DEPTH-1]`. Pointer `sp` is the next free slot, log2(DEPTH) bits, and wraps modulo DEPTH. `top = mem[sp-1 mod DEPTH]`.
- Reset state: `sp=0`, `count=0`, `outpop=0`, `ovf=0`, `udf=0`. Memory contents are not reset.
- Per cycle, decided on `{push,pop}`:
  - 00: hold.
  - 10, not full: `mem[sp]<=inpush`, `sp+1`, `count+1`.
  - 10, full, `WRAP=0`: no write, no state change, `ovf<=1`.
  - 10, full, `WRAP=1`: `mem[sp]<=inpush`, `sp+1`, count stays DEPTH, oldest entry lost, `ovf<=1`.
  - 01, not empty: `outpop<=top`, `sp-1`, `count-1`.
  - 01, empty: `outpop`/`sp`/`count` unchanged, `udf<=1`.
  - 11, not empty: replace top. `outpop<=top`, `mem[sp-1]<=inpush`, `sp`/`count` unchanged, no error (full included).
  - 11, empty: bypass. `outpop<=inpush`, stack unchanged, no error.
- `clr_err` clears `ovf` and `udf`. If an error event occurs in the same cycle, the set wins.
- `count` arithmetic never wraps: it saturates only via the rules above and is never outside 0..DEPTH.
- After wrapping (`WRAP=1`), pops return the DEPTH most recent pushes in LIFO order, then `empty` asserts.

## Timing
- Latency:
  - `outpop` is valid the cycle after the pop edge and holds until the next successful pop or bypass.
  - `top`, `full`, `empty` and `count` reflect the state after the edge, with no additional latency.
  - `top` is combinational from state only; there is no path from `push`/`pop`/`inpush` to `top`.
- Back-to-back operations every cycle are supported with no bubbles.
- Reset asserted mid-operation: control state clears asynchronously and any operation in that cycle is discarded. Normal operation resumes on the first rising edge after `reset` goes high.
- Inputs must be stable around the rising edge. No handshake: `push`/`pop` are single-cycle strobes and are always consumed.

## Test plan
- Reset then push 0x001..0x008 (DEPTH=8) → `full=1`, `count=8`, `top=0x008`. Then 8 pops → `outpop` sequence 0x008..0x001, `empty=1`, `ovf=udf=0`.
- `WRAP=0`, full, push 0x3FF → `count=8`, `top=0x008`, `ovf=1`. Then `clr_err` → `ovf=0`.
- `WRAP=1`, push 0x001..0x00A → `count=8`. Then 8 pops → `outpop` 0x00A..0x003, `empty=1`, `ovf=1`.
- Pop on empty → `udf=1`, `outpop` unchanged. Push+pop on empty with 0x155 → `outpop=0x155`, `empty=1`, no error.
- With 0x011,0x022 stacked, push+pop with 0x033 → `outpop=0x022`, `top=0x033`, `count=2`. Repeat when full → `count=8`, `ovf=0`.
- Pull `reset` low mid-sequence, asynchronously between edges → immediately `count=0`, `empty=1`, `outpop=0`, flags 0. A push one cycle after release → `count=1`.
